// File: rtl/bus_select_encoder_pkg.sv
// Shared types and constants for the bus select encoder: source indices and FSM state.
package bus_pkg;
    localparam int SEL_W = 5;
    localparam int SRC_N = 32;
    localparam int CNT_W = 8;

    localparam logic [SEL_W-1:0] SEL_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SEL_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SEL_ZHI    = 5'd18;
    localparam logic [SEL_W-1:0] SEL_ZLO    = 5'd19;
    localparam logic [SEL_W-1:0] SEL_PC     = 5'd20;
    localparam logic [SEL_W-1:0] SEL_MDR    = 5'd21;
    localparam logic [SEL_W-1:0] SEL_INPORT = 5'd22;
    localparam logic [SEL_W-1:0] SEL_C      = 5'd23;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } bus_state_e;
endpackage

// File: rtl/bus_select_encoder_if.sv
// Request/select handshake bundle between a bus requester (master) and the encoder (slave).
interface bus_select_encoder_if;
    import bus_pkg::*;

    logic [SRC_N-1:0] drive_req;
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] mux_select;
    logic             sel_valid;
    logic             sel_ack;
    logic             conflict;
    logic [CNT_W-1:0] conflict_count;

    modport slave (
        input  drive_req, req_valid, sel_ack,
        output req_ready, mux_select, sel_valid, conflict, conflict_count
    );

    modport master (
        output drive_req, req_valid, sel_ack,
        input  req_ready, mux_select, sel_valid, conflict, conflict_count
    );
endinterface

// File: rtl/bus_select_encoder_prio.sv
// 32-bit lowest-set-bit priority encoder with nonzero and multi-hot flags.
module prio_enc_32
    import bus_pkg::*;
(
    input  logic [SRC_N-1:0] i_req,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_nz,
    output logic             o_multi
);
    logic [SEL_W-1:0] w_idx;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        w_idx = '0;
        for (int i = SRC_N - 1; i >= 0; i--) begin
            if (i_req[i]) w_idx = SEL_W'(i);
        end
    end

    assign o_idx   = w_idx;
    assign o_nz    = |i_req;
    assign o_multi = |(i_req & (i_req - SRC_N'(1)));
endmodule

// File: rtl/bus_select_encoder.sv
// Bus source select encoder: one-hot requests to a held 32:1 mux select with ack handshake.
// Optional saturating conflict counter enabled by macro BUS_ENC_CONFLICT_CNT_EN.
module bus_select_encoder
    import bus_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    bus_select_encoder_if.slave  bus
);
    bus_state_e       r_state;
    logic [SEL_W-1:0] r_sel;
    logic             r_conflict;
    logic [SEL_W-1:0] w_idx;
    logic             w_nz;
    logic             w_multi;
    logic             w_ready;
    logic             w_accept;

    prio_enc_32 u_prio (
        .i_req   (bus.drive_req),
        .o_idx   (w_idx),
        .o_nz    (w_nz),
        .o_multi (w_multi)
    );

    assign w_ready  = clear && ((r_state == ST_IDLE) || bus.sel_ack);
    assign w_accept = bus.req_valid && w_ready && w_nz;

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= 1'b0;
            // An accept during ack hands over directly, keeping sel_valid high.
            if (w_accept) begin
                r_state    <= ST_DRIVE;
                r_sel      <= w_idx;
                r_conflict <= w_multi;
            end else if ((r_state == ST_DRIVE) && bus.sel_ack) begin
                r_state <= ST_IDLE;
            end
        end
    end

`ifdef BUS_ENC_CONFLICT_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Counts alongside the pulse so the count is visible in the same cycle.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_cnt <= '0;
        end else if (w_accept && w_multi && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.conflict_count = r_cnt;
`else
    assign bus.conflict_count = '0;
`endif

    assign bus.req_ready  = w_ready;
    assign bus.mux_select = r_sel;
    assign bus.sel_valid  = (r_state == ST_DRIVE);
    assign bus.conflict   = r_conflict;
endmodule

// File: doc/bus_select_encoder.md
BUS_SELECT_ENCODER -- requirements
Module: bus_select_encoder

Interface
REQ-001 Port clock, input, 1, rising-edge system clock.
REQ-002 Port clear, input, 1, reset; synchronous and active-low.
REQ-003 Port drive_req, input, 32, one-hot bus-drive requests; bit i = source i (R0..R15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, InPort=22, C=23, R24..R31).
REQ-004 Port req_valid, input, 1, drive_req is valid this cycle.
REQ-005 Port req_ready, output, 1, encoder accepts a request this cycle.
REQ-006 Port mux_select, output, 5, registered bus source index for the 32:1 bus multiplexer.
REQ-007 Port sel_valid, output, 1, mux_select is valid and held.
REQ-008 Port sel_ack, input, 1, bus consumer has captured the current bus value.
REQ-009 Port conflict, output, 1, one-cycle pulse: accepted request had more than one bit set.
REQ-010 Port conflict_count, output, 8, saturating count of conflicting accepted requests.

Function
REQ-011 Two states SHALL exist: IDLE (sel_valid=0) and DRIVE (sel_valid=1).
REQ-012 req_ready SHALL be combinational: 1 when state is IDLE, or when state is DRIVE and sel_ack=1; 0 while clear=0.
REQ-013 Acceptance SHALL occur on a rising edge with req_valid=1, req_ready=1 and drive_req nonzero.
REQ-014 On acceptance, mux_select SHALL load the index of the lowest set bit of drive_req and state SHALL become DRIVE; latency is one cycle to sel_valid=1.
REQ-015 req_valid=1 with drive_req=0 SHALL be ignored, with no state, select or flag change.
REQ-016 In DRIVE, mux_select SHALL remain stable until sel_ack=1.
REQ-017 On DRIVE with sel_ack=1 and no acceptance, state SHALL return to IDLE and mux_select SHALL hold its last value.
REQ-018 On DRIVE with sel_ack=1 and simultaneous acceptance, state SHALL stay DRIVE and mux_select SHALL load the new index, so sel_valid stays 1 with no bubble.
REQ-019 A request presented in DRIVE without sel_ack SHALL NOT be accepted or queued.
REQ-020 conflict SHALL be asserted for exactly the cycle after an accepted request with two or more bits set; otherwise 0.
REQ-021 conflict_count SHALL increment by one with each conflict pulse and saturate at 255.

Reset
REQ-022 While clear=0 at a rising edge: state=IDLE, mux_select=5'd0, sel_valid=0, conflict=0, conflict_count=0.
REQ-023 Reset asserted during DRIVE SHALL abandon the pending selection without requiring sel_ack.

Configuration
REQ-024 Macro BUS_ENC_CONFLICT_CNT_EN defined: conflict_count SHALL operate per REQ-021.
REQ-025 Macro BUS_ENC_CONFLICT_CNT_EN undefined: conflict_count SHALL be constant 0 with no counter flops; the port and the conflict pulse SHALL remain.

Structure
REQ-026 Shared package bus_pkg SHALL hold SEL_W=5, source index constants (SEL_HI=16, SEL_LO=17, SEL_ZHI=18, SEL_ZLO=19, SEL_PC=20, SEL_MDR=21, SEL_INPORT=22, SEL_C=23) and the IDLE/DRIVE state type.
REQ-027 One combinational sub-module prio_enc_32 SHALL produce the lowest-set-bit index, a nonzero flag and a multi-hot flag.

Verification
REQ-028 Release clear; drive_req=0x0010_0000 with req_valid for 1 cycle -> next cycle mux_select=20 (PC), sel_valid=1, conflict=0.
REQ-029 In DRIVE, hold sel_ack=0 for 5 cycles while presenting drive_req=0x0000_0001 -> req_ready=0, mux_select stays 20; then sel_ack=1 with no request -> IDLE, sel_valid=0.
REQ-030 In DRIVE at select 21 (MDR), sel_ack=1 together with drive_req=0x0001_0000 -> sel_valid stays 1 and mux_select=16 (HI) next cycle.
REQ-031 Accept drive_req=0x0028_0000 -> mux_select=19 (ZLO), conflict=1 for one cycle, conflict_count=1; 300 such requests -> conflict_count=255 with macro defined, 0 without.
REQ-032 req_valid=1 with drive_req=0 in IDLE -> no change; clear=0 asserted mid-DRIVE -> next cycle all outputs at the REQ-022 values.
